// File: rtl/xor_arbiter_pkg.sv
// Shared defaults, grant type and round-robin search helper for the XOR arbiter.
package xor_arbiter_pkg;

  localparam int N_DEF    = 4;
  localparam int W_DEF    = 8;
  localparam int IW_DEF   = $clog2(N_DEF);
  localparam int MAX_N    = 32;
  localparam int RR_IDX_W = 5;

  typedef logic [N_DEF-1:0] grant_t;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid[n-1:0] searching upward from ptr with wrap at n.
  // ptr < n and i < n, so a single subtraction brings the candidate back in range.
  function automatic rr_pick_t rr_next(input logic [RR_IDX_W-1:0] ptr,
                                       input logic [MAX_N-1:0]    valid,
                                       input int                  n);
    rr_pick_t            res;
    logic [RR_IDX_W:0]   cand;
    res.found = 1'b0;
    res.idx   = '0;
    for (int i = 0; i < MAX_N; i++) begin
      if (i < n && !res.found) begin
        cand = {1'b0, ptr} + (RR_IDX_W+1)'(i);
        if (cand >= (RR_IDX_W+1)'(n)) cand = cand - (RR_IDX_W+1)'(n);
        if (valid[cand[RR_IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = cand[RR_IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/xor_arbiter_if.sv
// Requester and consumer handshake bundle for xor_arbiter.
interface xor_arbiter_if
  import xor_arbiter_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int IW = IW_DEF
) ();

  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [IW-1:0]  resp_id;
  logic [W-1:0]   resp_y;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_id, resp_y
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_id, resp_y
  );

endinterface

// File: rtl/xor_arbiter_xor_unit.sv
// Shared combinational XOR kernel placed behind the grant mux.
module xor_unit
  import xor_arbiter_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_arbiter.sv
// Round-robin arbiter sharing one XOR kernel among N requesters, with a
// single-entry registered result. Supports N up to MAX_N (32).
module xor_arbiter
  import xor_arbiter_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clock,
  input  logic          reset,
  xor_arbiter_if.slave  bus
);

  logic [MAX_N-1:0] valid_ext;
  rr_pick_t         pick;
  logic             slot_free;
  logic             grant_en;
  logic [IW-1:0]    gnt_idx;
  logic [N-1:0]     ready;
  logic [W-1:0]     a_sel;
  logic [W-1:0]     b_sel;
  logic [W-1:0]     y_sel;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    ptr_next;

  logic             vld_p1;
  logic [W-1:0]     y_p1;
  logic [IW-1:0]    id_p1;

  // Stage 0: arbitrate and select the granted operand pair
  always_comb begin
    valid_ext          = '0;
    valid_ext[N-1:0]   = bus.req_valid;
    pick               = rr_next(RR_IDX_W'(ptr), valid_ext, N);
    slot_free          = !vld_p1 || bus.resp_ready;
    grant_en           = !reset && slot_free && pick.found;
    gnt_idx            = IW'(pick.idx);
    ready              = '0;
    if (grant_en) ready[gnt_idx] = 1'b1;
    a_sel              = bus.req_a[int'(gnt_idx)*W +: W];
    b_sel              = bus.req_b[int'(gnt_idx)*W +: W];
    ptr_next           = (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
  end

  xor_unit #(.W(W)) u_xor (
    .a (a_sel),
    .b (b_sel),
    .y (y_sel)
  );

  // Stage 1: output register; drain and refill may share one edge
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
      y_p1   <= '0;
      id_p1  <= '0;
      ptr    <= '0;
    end else if (grant_en) begin
      vld_p1 <= 1'b1;
      y_p1   <= y_sel;
      id_p1  <= gnt_idx;
      ptr    <= ptr_next;
    end else if (vld_p1 && bus.resp_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.req_ready  = ready;
  assign bus.resp_valid = vld_p1;
  assign bus.resp_y     = y_p1;
  assign bus.resp_id    = id_p1;

  a_grant_onehot : assert property (@(posedge clock) $onehot0(ready));
  a_grant_valid  : assert property (@(posedge clock) (ready & ~bus.req_valid) == '0);

endmodule

// File: tb/tb_xor_arbiter.sv
// Scenario bench for xor_arbiter with a round-robin reference model and result scoreboard.
module tb_xor_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    logic [1:0] id;
    logic [7:0] y;
  } exp_t;

  logic clk;
  logic reset;
  logic reset3;
  int   n_checks;
  int   n_pass;

  exp_t sb[$];
  exp_t e;
  int   m_ptr;
  logic m_full;
  logic armed;
  int   exp_g;
  int   c;
  logic [N-1:0] exp_rdy;

  xor_arbiter_if #(.N(4), .W(8), .IW(2)) bus ();
  xor_arbiter_if #(.N(3), .W(4), .IW(2)) bus3 ();

  xor_arbiter #(.N(4), .W(8), .IW(2)) u_dut (
    .clock (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  xor_arbiter #(.N(3), .W(4), .IW(2)) u_dut3 (
    .clock (clk),
    .reset (reset3),
    .bus   (bus3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_pair(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[i*W +: W] = a;
    bus.req_b[i*W +: W] = b;
  endtask

  // Reference model and scoreboard, sampled mid-cycle after inputs settle
  always @(negedge clk) begin
    #2;
    if (reset === 1'b1) begin
      m_ptr  = 0;
      m_full = 1'b0;
      sb.delete();
      armed  = 1'b1;
      n_checks++;
      if (bus.req_ready !== 4'b0000)
        $display("FAIL mon_reset_ready: got %b want 0000", bus.req_ready);
      else n_pass++;
    end else if (armed) begin
      exp_g = -1;
      if (!m_full || bus.resp_ready) begin
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (exp_g < 0 && bus.req_valid[c]) exp_g = c;
        end
      end
      exp_rdy = (exp_g >= 0) ? 4'(1 << exp_g) : 4'b0000;
      n_checks++;
      if (bus.req_ready !== exp_rdy)
        $display("FAIL mon_grant: got %b want %b", bus.req_ready, exp_rdy);
      else n_pass++;
      n_checks++;
      if (bus.resp_valid !== m_full)
        $display("FAIL mon_resp_valid: got %b want %b", bus.resp_valid, m_full);
      else n_pass++;
      if (m_full && bus.resp_ready) begin
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL mon_sb_empty: got result id=%0d y=%h want none", bus.resp_id, bus.resp_y);
        end else begin
          e = sb.pop_front();
          if (bus.resp_id !== e.id || bus.resp_y !== e.y)
            $display("FAIL mon_result: got id=%0d y=%h want id=%0d y=%h",
                     bus.resp_id, bus.resp_y, e.id, e.y);
          else n_pass++;
        end
        m_full = 1'b0;
      end
      if (exp_g >= 0) begin
        e.id = 2'(exp_g);
        e.y  = bus.req_a[exp_g*W +: W] ^ bus.req_b[exp_g*W +: W];
        sb.push_back(e);
        m_full = 1'b1;
        m_ptr  = (exp_g + 1) % N;
      end
    end
  end

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid  = '1;
    bus.resp_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0000) $display("FAIL reset_ready_in_reset: got %b want 0000", bus.req_ready);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = '0;
    repeat (5) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.resp_valid !== 1'b0 || bus.resp_y !== 8'h00 || bus.resp_id !== 2'd0 || bus.req_ready !== 4'b0000)
        $display("FAIL reset_idle: got v=%b y=%h id=%0d rdy=%b want 0 00 0 0000",
                 bus.resp_valid, bus.resp_y, bus.resp_id, bus.req_ready);
      else n_pass++;
    end
  endtask

  task automatic test_single();
    @(negedge clk);
    set_pair(2, 8'hA5, 8'h0F);
    bus.req_valid  = 4'b0100;
    bus.resp_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0100) $display("FAIL single_grant: got %b want 0100", bus.req_ready);
    else n_pass++;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_y !== 8'hAA || bus.resp_id !== 2'd2)
      $display("FAIL single_result: got v=%b y=%h id=%0d want 1 aa 2", bus.resp_valid, bus.resp_y, bus.resp_id);
    else n_pass++;
    n_checks++;
    if (u_dut.ptr !== 2'd3) $display("FAIL single_ptr: got %0d want 3", u_dut.ptr);
    else n_pass++;
    @(negedge clk);
    #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0) $display("FAIL single_drain: got %b want 0", bus.resp_valid);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    logic [7:0] ya[N];
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      set_pair(i, 8'(17 * (i + 1)), 8'(8'hC3 ^ i));
      ya[i] = 8'(17 * (i + 1)) ^ 8'(8'hC3 ^ i);
    end
    bus.req_valid  = '1;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== 4'(1 << (k % N)))
        $display("FAIL rr_grant_%0d: got %b want %b", k, bus.req_ready, 4'(1 << (k % N)));
      else n_pass++;
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.resp_valid !== 1'b1 || bus.resp_id !== 2'(k % N) || bus.resp_y !== ya[k % N])
        $display("FAIL rr_result_%0d: got v=%b id=%0d y=%h want 1 %0d %h",
                 k, bus.resp_valid, bus.resp_id, bus.resp_y, k % N, ya[k % N]);
      else n_pass++;
    end
    bus.req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    set_pair(0, 8'h5A, 8'h00);
    bus.req_valid  = 4'b0001;
    bus.resp_ready = 1'b0;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0001) $display("FAIL bp_first_grant: got %b want 0001", bus.req_ready);
    else n_pass++;
    @(negedge clk);
    set_pair(1, 8'h81, 8'h18);
    set_pair(3, 8'hC0, 8'h0C);
    bus.req_valid = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      #1;
      n_checks++;
      if (bus.req_ready !== 4'b0000 || bus.resp_valid !== 1'b1 || bus.resp_y !== 8'h5A || bus.resp_id !== 2'd0)
        $display("FAIL bp_hold_%0d: got rdy=%b v=%b y=%h id=%0d want 0000 1 5a 0",
                 k, bus.req_ready, bus.resp_valid, bus.resp_y, bus.resp_id);
      else n_pass++;
      @(negedge clk);
    end
    bus.resp_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0010) $display("FAIL bp_release_grant: got %b want 0010", bus.req_ready);
    else n_pass++;
    @(negedge clk);
    bus.req_valid = 4'b1000;
    #1;
    n_checks++;
    if (bus.resp_id !== 2'd1 || bus.resp_y !== 8'h99 || bus.req_ready !== 4'b1000)
      $display("FAIL bp_after_release: got id=%0d y=%h rdy=%b want 1 99 1000", bus.resp_id, bus.resp_y, bus.req_ready);
    else n_pass++;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    n_checks++;
    if (bus.resp_id !== 2'd3 || bus.resp_y !== 8'hCC)
      $display("FAIL bp_second: got id=%0d y=%h want 3 cc", bus.resp_id, bus.resp_y);
    else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_reset_full();
    @(negedge clk);
    reset = 1'b1;
    bus.req_valid = '0;
    @(negedge clk);
    reset = 1'b0;
    set_pair(1, 8'h33, 8'h0F);
    bus.req_valid  = 4'b0010;
    bus.resp_ready = 1'b0;
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    n_checks++;
    if (bus.resp_valid !== 1'b1 || bus.resp_y !== 8'h3C)
      $display("FAIL rstfull_loaded: got v=%b y=%h want 1 3c", bus.resp_valid, bus.resp_y);
    else n_pass++;
    @(negedge clk);
    reset = 1'b1;
    bus.resp_ready = 1'b1;
    bus.req_valid  = '1;
    #1;
    n_checks++;
    if (bus.req_ready !== 4'b0000) $display("FAIL rstfull_ready: got %b want 0000", bus.req_ready);
    else n_pass++;
    @(negedge clk);
    reset = 1'b0;
    bus.req_valid = '0;
    #1;
    n_checks++;
    if (bus.resp_valid !== 1'b0 || bus.resp_y !== 8'h00 || bus.resp_id !== 2'd0 || u_dut.ptr !== 2'd0)
      $display("FAIL rstfull_cleared: got v=%b y=%h id=%0d ptr=%0d want 0 00 0 0",
               bus.resp_valid, bus.resp_y, bus.resp_id, u_dut.ptr);
    else n_pass++;
    repeat (2) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (bus.resp_valid !== 1'b0) $display("FAIL rstfull_no_delivery: got %b want 0", bus.resp_valid);
      else n_pass++;
    end
  endtask

  task automatic test_wrap_n3();
    @(negedge clk);
    reset3 = 1'b1;
    @(negedge clk);
    reset3 = 1'b0;
    bus3.req_a = {4'h0, 4'h6, 4'h9};
    bus3.req_b = {4'h0, 4'h5, 4'h3};
    bus3.req_valid  = 3'b010;
    bus3.resp_ready = 1'b1;
    #1;
    n_checks++;
    if (bus3.req_ready !== 3'b010) $display("FAIL wrap_grant1: got %b want 010", bus3.req_ready);
    else n_pass++;
    @(negedge clk);
    bus3.req_valid = 3'b001;
    #1;
    n_checks++;
    if (u_dut3.ptr !== 2'd2 || bus3.resp_y !== 4'h3)
      $display("FAIL wrap_setup: got ptr=%0d y=%h want 2 3", u_dut3.ptr, bus3.resp_y);
    else n_pass++;
    n_checks++;
    if (bus3.req_ready !== 3'b001) $display("FAIL wrap_grant0: got %b want 001", bus3.req_ready);
    else n_pass++;
    @(negedge clk);
    bus3.req_valid = '0;
    #1;
    n_checks++;
    if (bus3.resp_id !== 2'd0 || bus3.resp_y !== 4'hA || u_dut3.ptr !== 2'd1)
      $display("FAIL wrap_result: got id=%0d y=%h ptr=%0d want 0 a 1", bus3.resp_id, bus3.resp_y, u_dut3.ptr);
    else n_pass++;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    armed    = 1'b0;
    m_ptr    = 0;
    m_full   = 1'b0;
    reset    = 1'b1;
    reset3   = 1'b1;
    bus.req_valid   = '0;
    bus.req_a       = '0;
    bus.req_b       = '0;
    bus.resp_ready  = 1'b0;
    bus3.req_valid  = '0;
    bus3.req_a      = '0;
    bus3.req_b      = '0;
    bus3.resp_ready = 1'b0;

    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_reset_full();
    test_wrap_n3();

    @(negedge clk);
    #1;
    n_checks++;
    if (sb.size() != 0) $display("FAIL sb_leftover: got %0d entries want 0", sb.size());
    else n_pass++;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xor_arbiter.md
# xor_arbiter

Shares one W-bit XOR datapath (the `xor_unit` kernel) among N requesters under round-robin arbitration. Each requester offers an operand pair with a valid/ready handshake. The block grants one requester per cycle, computes `a ^ b`, and holds the result in a single-entry output register until the consumer accepts it. It sits between request-generating sub-blocks and a single downstream consumer, and replaces N private XOR gates with one scheduled unit.

## Interface
Parameters:
- `N`, default 4: number of requesters, N ≥ 2.
- `W`, default 8: operand and result width in bits.
- `IW`, default clog2(N): width of the requester ID.

Ports:
- `clock`, in, 1: single clock. All state updates on the rising edge.
- `reset`, in, 1: synchronous, active-high reset.
- `req_valid`, in, N: bit i high means requester i offers an operand pair.
- `req_ready`, out, N: one-hot grant. Bit i high means requester i's pair is taken this cycle.
- `req_a`, in, N*W: operand A. Requester i occupies bits [i*W +: W].
- `req_b`, in, N*W: operand B, packed the same way as `req_a`.
- `resp_valid`, out, 1: output register holds a result.
- `resp_ready`, in, 1: consumer accepts the result this cycle.
- `resp_id`, out, IW: index of the requester that produced the result.
- `resp_y`, out, W: the result, `a ^ b`.

## Operation
- State is the output-register occupancy: EMPTY (`resp_valid`=0) or FULL (`resp_valid`=1). There is also a round-robin pointer `ptr` (IW bits).
- `slot_free` = EMPTY, or (FULL and `resp_ready`).
- Grant rule: when `slot_free` is true and any `req_valid` bit is set, grant the first set bit found searching upward from `ptr`, wrapping from N-1 to 0. Otherwise `req_ready` is all zeros.
- `req_ready` is purely combinational from `req_valid`, `ptr`, `resp_valid` and `resp_ready`. It never asserts for a requester whose `req_valid` is low.
- On a grant to requester g at the clock edge:
  - `resp_y` ← `req_a[g] ^ req_b[g]`
  - `resp_id` ← g
  - `resp_valid` ← 1
  - `ptr` ← (g+1) mod N. The wrap is explicit and correct for N that is not a power of two.
- If FULL, `resp_ready`=1 and no grant occurs: `resp_valid` ← 0. `resp_y` and `resp_id` keep their last values.
- If FULL and `resp_ready`=0: all outputs hold and `req_ready`=0. This is backpressure.
- If there is no grant, `ptr` does not change.
- Requesters must hold `req_valid`, `req_a` and `req_b` stable until their ready bit is seen. The block does not check this.
- Reset values: `resp_valid`=0, `resp_id`=0, `resp_y`=0, `ptr`=0. `req_ready`=0 for every cycle in which `reset` is high.
- Reset mid-operation: a result in the output register is discarded, not delivered. Requesters see no grant while reset is high.

## Timing
- Latency is 1 cycle: a pair accepted at edge k has `resp_valid`=1 from edge k onward.
- Full throughput: one result per cycle when `resp_ready` is held high. The drain and the refill happen at the same edge.
- There is no combinational path from `req_a` or `req_b` to any output. `resp_y` is registered.
- There is a combinational path from `resp_ready` to `req_ready`. Upstream logic must not make `req_valid` depend on `req_ready`.
- Fairness: a requester holding `req_valid` high is granted within N grants.

## Structure
Shared package contents:
- the `N`, `W` and `IW` defaults
- a `grant_t` typedef (one-hot, N bits)
- a `rr_next(ptr, valid)` function that returns the granted index and a found flag

Sub-module `xor_unit`: a combinational W-bit `y = a ^ b` kernel, instantiated once behind the grant mux. The arbiter, pointer and output register stay in `xor_arbiter`.

## Test plan
1. Reset, then idle with all `req_valid`=0 for 5 cycles: `resp_valid`=0, `resp_y`=0x00, `resp_id`=0, `req_ready`=0000 every cycle.
2. Single request, requester 2 with a=0xA5, b=0x0F, `resp_ready`=1:
   - `req_ready`=0100 for one cycle.
   - Next cycle: `resp_valid`=1, `resp_y`=0xAA, `resp_id`=2.
   - `ptr` becomes 3.
3. All four requesters valid continuously, `resp_ready`=1, starting from reset:
   - Grants go 0,1,2,3,0 on consecutive cycles.
   - `resp_id` follows the same sequence, delayed by one cycle.
4. Backpressure: FULL with `resp_ready`=0 for 3 cycles while requesters 1 and 3 are valid:
   - `req_ready`=0000, and `resp_y` and `resp_id` stay stable.
   - When `resp_ready` rises, requester 1 is granted in that same cycle.
5. Wrap with N=3, W=4: `ptr`=2 and only requester 0 valid → grant 0, and `ptr` becomes 1 (not 3).
6. Reset asserted while FULL (`resp_y`=0x3C): the next cycle shows `resp_valid`=0, `resp_y`=0x00, `ptr`=0, and the pending result is never delivered.
